cnn_tile_scheduler: RTL and testbench

- Sequences the CNN data mover over a batch of tiles.
- Per tile: waits for the mover to be idle, issues a one-cycle run pulse, waits for its done pulse, then advances the BRAM0/1/2 base addresses by fixed per-tile strides.
- Sits between the host control registers and the data mover; adds tile counting, weight reuse, abort and a watchdog timeout.

---
 rtl/cnn_sched_pkg.sv | 31 +++
 rtl/cnn_tile_scheduler_if.sv | 24 ++
 rtl/cnn_addr_accum.sv | 17 +
 rtl/cnn_tile_scheduler.sv | 126 ++++++++++++
 tb/tb_cnn_tile_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared constants for the CNN tile scheduler and the data mover it drives.
// State encodings are fixed 3-bit values so they can be matched in debug dumps.
package cnn_sched_pkg;

  localparam int TILE_CNT_W_DEF   = 8;
  localparam int TIMEOUT_W_DEF    = 16;

  // Per-tile word footprints; the data mover uses the same layout.
  localparam int BRAM0_STRIDE_DEF = 7;
  localparam int BRAM1_STRIDE_DEF = 36;
  localparam int BRAM2_STRIDE_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARM   = ST_ARM,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT,
    S_FIN   = ST_FIN,
    S_ERR   = ST_ERR
  } sched_state_e;

endpackage

// File: rtl/cnn_tile_scheduler_if.sv
// Scheduler <-> data mover link: run/idle/done handshake plus per-tile bases.
// master = scheduler side, slave = data mover side.
interface cnn_tile_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TILE_CNT_W = 8
);
  logic                  i_mv_idle;
  logic                  i_mv_done;
  logic                  o_mv_run;
  logic [ADDR_WIDTH-1:0] o_bram0_base;
  logic [ADDR_WIDTH-1:0] o_bram1_base;
  logic [ADDR_WIDTH-1:0] o_bram2_base;
  logic [TILE_CNT_W-1:0] o_tile_idx;

  modport master (
    input  i_mv_idle, i_mv_done,
    output o_mv_run, o_bram0_base, o_bram1_base, o_bram2_base, o_tile_idx
  );

  modport slave (
    output i_mv_idle, i_mv_done,
    input  o_mv_run, o_bram0_base, o_bram1_base, o_bram2_base, o_tile_idx
  );
endinterface

// File: rtl/cnn_addr_accum.sv
// Base-address accumulator: base = tile_idx * STRIDE built by repeated addition.
// Wraps modulo 2^ADDR_WIDTH.
module cnn_addr_accum #(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned STRIDE     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  add,
  output logic [ADDR_WIDTH-1:0] base
);
  always_ff @(posedge clk) begin
    if (reset || clr) base <= '0;
    else if (add)     base <= base + ADDR_WIDTH'(STRIDE);
  end
endmodule

// File: rtl/cnn_tile_scheduler.sv
// Walks the data mover through a batch of tiles: arm on idle, pulse run,
// wait for done (with watchdog), step the BRAM bases, repeat.
module cnn_tile_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int TILE_CNT_W   = TILE_CNT_W_DEF,
  parameter int BRAM0_STRIDE = BRAM0_STRIDE_DEF,
  parameter int BRAM1_STRIDE = BRAM1_STRIDE_DEF,
  parameter int BRAM2_STRIDE = BRAM2_STRIDE_DEF,
  parameter int TIMEOUT_W    = TIMEOUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [TILE_CNT_W-1:0] i_num_tiles,
  input  logic                  i_reuse_weight,
  input  logic [TIMEOUT_W-1:0]  i_timeout_limit,
  input  logic                  i_abort,
  cnn_tile_scheduler_if.master  mv,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_timeout
);
  localparam int          NUM_BASE = 3;
  localparam int unsigned STRIDE [NUM_BASE] = '{BRAM0_STRIDE, BRAM1_STRIDE, BRAM2_STRIDE};

  typedef struct packed {
    logic [TILE_CNT_W-1:0] num_tiles;
    logic                  reuse;
    logic [TIMEOUT_W-1:0]  limit;
  } cfg_t;

  sched_state_e state, state_n;
  cfg_t                                cfg;
  logic [TILE_CNT_W-1:0]               tile_idx;
  logic [TIMEOUT_W-1:0]                wd_cnt;
  logic                                err;
  logic                                start_acc, last_tile, wd_hit, advance, run;
  logic [NUM_BASE-1:0][ADDR_WIDTH-1:0] base;

  assign start_acc = (state == S_IDLE) && i_start;
  assign last_tile = (tile_idx == cfg.num_tiles - TILE_CNT_W'(1));
  assign wd_hit    = (cfg.limit != '0) && (wd_cnt == cfg.limit - TIMEOUT_W'(1));
  // Abort wins over the step so an aborted batch keeps the bases of the tile it stopped on.
  assign advance   = (state == S_NEXT) && !last_tile && !i_abort;

  always_comb begin
    state_n = state;
    run     = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_n = (i_num_tiles == '0) ? S_FIN : S_ARM;
      end
      S_ARM:   if (i_mv_idle_q()) state_n = S_ISSUE;
      S_ISSUE: begin
        run     = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mv.i_mv_done) state_n = S_NEXT;
        else if (wd_hit)  state_n = S_ERR;
      end
      S_NEXT:  state_n = last_tile ? S_FIN : S_ARM;
      S_FIN: begin
        o_done  = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
    // ERR is only left through abort; IDLE has nothing to abort.
    if (i_abort && state != S_IDLE) state_n = S_IDLE;
  end

  function automatic logic i_mv_idle_q();
    return mv.i_mv_idle;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cfg      <= '0;
      tile_idx <= '0;
      wd_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        cfg      <= '{num_tiles: i_num_tiles, reuse: i_reuse_weight, limit: i_timeout_limit};
        tile_idx <= '0;
        err      <= 1'b0;
      end
      if (advance) tile_idx <= tile_idx + TILE_CNT_W'(1);
      if (state == S_ISSUE)                      wd_cnt <= '0;
      else if (state == S_WAIT && !mv.i_mv_done) wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      if (state == S_WAIT && !mv.i_mv_done && wd_hit && !i_abort) err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BASE; g++) begin : g_base
    // Only the weight base (BRAM1) is frozen when weights are reused.
    localparam bit REUSE_GATED = (g == 1);
    cnn_addr_accum #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRIDE     (STRIDE[g])
    ) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (start_acc),
      .add   (advance && !(REUSE_GATED && cfg.reuse)),
      .base  (base[g])
    );
  end

  assign mv.o_mv_run     = run;
  assign mv.o_bram0_base = base[0];
  assign mv.o_bram1_base = base[1];
  assign mv.o_bram2_base = base[2];
  assign mv.o_tile_idx   = tile_idx;
  assign o_err_timeout   = err;

endmodule

// File: tb/tb_cnn_tile_scheduler.sv
// Scoreboarded bench: stimulus pushes expected run/done events, a negedge
// monitor pops and compares them; a small mover model answers run with done.
module tb_cnn_tile_scheduler;
  localparam int AW = 32, TW = 8, OW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, i_reuse_weight, i_abort;
  logic [TW-1:0] i_num_tiles;
  logic [OW-1:0] i_timeout_limit;
  logic          o_busy, o_done, o_err_timeout;

  cnn_tile_scheduler_if #(.ADDR_WIDTH(AW), .TILE_CNT_W(TW)) mv ();

  cnn_tile_scheduler #(.ADDR_WIDTH(AW), .TILE_CNT_W(TW), .TIMEOUT_W(OW)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_num_tiles     (i_num_tiles),
    .i_reuse_weight  (i_reuse_weight),
    .i_timeout_limit (i_timeout_limit),
    .i_abort         (i_abort),
    .mv              (mv.master),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err_timeout   (o_err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tile;
    logic [AW-1:0] b0, b1, b2;
    int          ref_e;
    int          lat_lo, lat_hi;
    bit          use_mv;
  } exp_t;

  exp_t run_q[$];
  exp_t done_q[$];
  int   n_chk = 0, n_fail = 0;
  int   runs_seen = 0, last_run_edge = 0, last_done_edge = 0;
  int   mv_delay = 20;
  bit   mv_hang = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Mover model: done pulse mv_delay cycles after each run it sees.
  initial begin
    mv.i_mv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mv.o_mv_run === 1'b1 && !mv_hang) begin
        repeat (mv_delay) @(negedge clk);
        mv.i_mv_done   = 1'b1;
        last_done_edge = cyc + 1;
        @(negedge clk);
        mv.i_mv_done = 1'b0;
      end
    end
  end

  // Monitor: every run / done the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (mv.o_mv_run === 1'b1) begin
        runs_seen++;
        last_run_edge = cyc + 1;
        if (run_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL run_extra: run at tile %0d, expected no run", mv.o_tile_idx);
        end else begin
          e = run_q.pop_front();
          chk("run_tile", 64'(mv.o_tile_idx), 64'(e.tile));
          chk("run_b0", 64'(mv.o_bram0_base), 64'(e.b0));
          chk("run_b1", 64'(mv.o_bram1_base), 64'(e.b1));
          chk("run_b2", 64'(mv.o_bram2_base), 64'(e.b2));
          if (e.lat_hi != 0) chk_rng("run_lat", cyc + 1 - e.ref_e, e.lat_lo, e.lat_hi);
        end
      end
      if (o_done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done_extra: done pulse at tile %0d, expected none", mv.o_tile_idx);
        end else begin
          e = done_q.pop_front();
          chk("done_tile", 64'(mv.o_tile_idx), 64'(e.tile));
          chk("done_b0", 64'(mv.o_bram0_base), 64'(e.b0));
          chk("done_b1", 64'(mv.o_bram1_base), 64'(e.b1));
          chk("done_b2", 64'(mv.o_bram2_base), 64'(e.b2));
          chk_rng("done_lat", cyc + 1 - (e.use_mv ? last_done_edge : e.ref_e), e.lat_lo, e.lat_hi);
        end
      end
    end
  end

  function automatic exp_t mk(input int t, input bit reuse);
    exp_t e;
    e.tile = t;
    e.b0 = AW'(t * 7);
    e.b1 = reuse ? '0 : AW'(t * 36);
    e.b2 = AW'(t * 16);
    e.ref_e = 0; e.lat_lo = 0; e.lat_hi = 0; e.use_mv = 0;
    return e;
  endfunction

  // Called at a negedge; returns one negedge later with start dropped.
  task automatic start(input int n, input bit reuse, input int limit,
                       input int nruns, input bit exp_done, input int lat);
    exp_t e;
    int   se;
    i_num_tiles = TW'(n); i_reuse_weight = reuse; i_timeout_limit = OW'(limit);
    i_start = 1'b1;
    se = cyc + 1;
    for (int t = 0; t < nruns; t++) begin
      e = mk(t, reuse);
      e.ref_e = se;
      if (t == 0) begin e.lat_lo = lat; e.lat_hi = lat; end
      run_q.push_back(e);
    end
    if (exp_done) begin
      e = mk((n == 0) ? 0 : n - 1, reuse);
      e.ref_e  = se;
      e.use_mv = (n != 0);
      e.lat_lo = (n == 0) ? 1 : 2;
      e.lat_hi = 2;
      done_q.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((run_q.size() != 0 || done_q.size() != 0 || o_busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: not finished after %0d cycles, runs pending %0d, done pending %0d",
               name, budget, run_q.size(), done_q.size());
      run_q.delete(); done_q.delete();
    end
  endtask

  task automatic wait_runs(input string name, input int target);
    int k = 0;
    while (runs_seen < target && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL %s: runs seen %0d, expected %0d", name, runs_seen, target);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_run"},  64'(mv.o_mv_run), 0);
    chk({tag, "_b0"},   64'(mv.o_bram0_base), 0);
    chk({tag, "_b1"},   64'(mv.o_bram1_base), 0);
    chk({tag, "_b2"},   64'(mv.o_bram2_base), 0);
    chk({tag, "_idx"},  64'(mv.o_tile_idx), 0);
    chk({tag, "_busy"}, 64'(o_busy), 0);
    chk({tag, "_done"}, 64'(o_done), 0);
    chk({tag, "_err"},  64'(o_err_timeout), 0);
  endtask

  initial begin
    int base_runs, k, n;
    bit reuse;
    reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_reuse_weight = 1'b0;
    i_num_tiles = '0; i_timeout_limit = '0; mv.i_mv_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Zero-tile batch: done only, no run, bases untouched.
    base_runs = runs_seen;
    start(0, 0, 0, 0, 1, 0);
    wait_drain("zero", 10);
    chk("zero_runs", 64'(runs_seen - base_runs), 0);
    chk("zero_b0", 64'(mv.o_bram0_base), 0);

    // Three tiles, no reuse.
    mv_delay = 20; base_runs = runs_seen;
    start(3, 0, 0, 3, 1, 2);
    wait_drain("t3", 300);
    chk("t3_runs", 64'(runs_seen - base_runs), 3);
    chk("t3_busy", 64'(o_busy), 0);

    // Weight reuse.
    mv_delay = 5;
    start(2, 1, 0, 2, 1, 2);
    wait_drain("reuse", 200);

    // Watchdog: mover never answers.
    mv_hang = 1'b1;
    start(1, 0, 50, 1, 0, 2);
    k = 0;
    while (o_err_timeout !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("to_lat", 64'(cyc - last_run_edge), 50);
    chk("to_busy", 64'(o_busy), 1);
    repeat (5) @(negedge clk);
    chk("to_sticky", 64'(o_err_timeout), 1);
    i_abort = 1'b1; @(negedge clk); i_abort = 1'b0;
    chk("to_abort_busy", 64'(o_busy), 0);
    chk("to_abort_err", 64'(o_err_timeout), 1);
    mv_hang = 1'b0;
    start(1, 0, 0, 1, 1, 2);
    chk("to_err_clr", 64'(o_err_timeout), 0);
    wait_drain("to_restart", 200);

    // Abort in WAIT of tile 1 of 4; a start while busy is ignored.
    mv_delay = 20; base_runs = runs_seen;
    start(4, 0, 0, 2, 0, 2);
    wait_runs("abort_runs", base_runs + 2);
    repeat (3) @(negedge clk);
    i_num_tiles = 8'd9; i_start = 1'b1; @(negedge clk); i_start = 1'b0;
    chk("abort_busy_pre", 64'(o_busy), 1);
    i_abort = 1'b1; @(negedge clk); i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy), 0);
    chk("abort_run", 64'(mv.o_mv_run), 0);
    repeat (40) @(negedge clk);
    chk("abort_total", 64'(runs_seen - base_runs), 2);

    // Mover busy for 10 ARM cycles: run follows idle rising.
    mv.i_mv_idle = 1'b0;
    start(1, 0, 0, 1, 1, 12);
    repeat (10) @(negedge clk);
    mv.i_mv_idle = 1'b1;
    wait_drain("arm_wait", 200);

    // Reset in the middle of WAIT.
    base_runs = runs_seen;
    start(2, 0, 0, 1, 0, 2);
    wait_runs("rstw_runs", base_runs + 1);
    repeat (3) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    chk_all_zero("rstw");
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // Randomized batches.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      reuse = 1'($urandom_range(0, 1));
      mv_delay = $urandom_range(1, 8);
      start(n, reuse, ($urandom_range(0, 1) != 0) ? 40 : 0, n, 1, 2);
      wait_drain("rand", 500);
    end

    // Largest legal batch: tile index must reach 254 without wrapping.
    mv_delay = 1;
    start(255, 1'($urandom_range(0, 1)), 0, 255, 1, 2);
    wait_drain("max", 6000);
    chk("max_busy", 64'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
